// File: rtl/cpu_nios_debug_cmd_bridge.sv
// Bridges JTAG update-IR/update-DR strobes into the clk domain and queues
// {instruction, shifted data} commands for a consumer with ready/valid pop.
`timescale 1ns/1ps
module cpu_nios_debug_cmd_bridge #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 35,
    localparam int NUM_CMD    = 2**IR_W,
    localparam int CW         = $clog2(DEPTH+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vs_uir,
    input  logic               vs_udr,
    input  logic [IR_W-1:0]    ir_in,
    input  logic [SR_W-1:0]    sr,
    input  logic               cmd_ready,
    input  logic               ovf_clr,
    output logic               cmd_valid,
    output logic [IR_W-1:0]    cmd_ir,
    output logic [SR_W-1:0]    cmd_data,
    output logic [NUM_CMD-1:0] take_action,
    output logic [NUM_CMD-1:0] take_no_action,
    output logic [CW-1:0]      fill_level,
    output logic               overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SYNC_STAGES-1:0] uir_sync_p0;
    logic [SYNC_STAGES-1:0] udr_sync_p0;
    logic                   uir_dly_p1;
    logic                   udr_dly_p1;
    logic [SYNC_STAGES:0]   warm;
    logic                   uir_rise;
    logic                   udr_rise;
    logic [IR_W-1:0]        ir_reg;

    logic [IR_W-1:0]        mem_ir   [DEPTH];
    logic [SR_W-1:0]        mem_data [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   pop;
    logic                   wr_en;
    logic                   drop;
    logic [NUM_CMD-1:0]     head_onehot;

    // Stage p0/p1: synchronizer chains and edge-detect delay flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uir_sync_p0 <= '0;
            udr_sync_p0 <= '0;
            uir_dly_p1  <= 1'b0;
            udr_dly_p1  <= 1'b0;
            warm        <= '0;
        end else begin
            uir_sync_p0 <= {uir_sync_p0[SYNC_STAGES-2:0], vs_uir};
            udr_sync_p0 <= {udr_sync_p0[SYNC_STAGES-2:0], vs_udr};
            uir_dly_p1  <= uir_sync_p0[SYNC_STAGES-1];
            udr_dly_p1  <= udr_sync_p0[SYNC_STAGES-1];
            warm        <= {warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are only trusted once the delay flop holds a real post-reset
    // sample, so a strobe already high at reset release is not a new command.
    always_comb begin
        uir_rise = uir_sync_p0[SYNC_STAGES-1] & ~uir_dly_p1 & warm[SYNC_STAGES];
        udr_rise = udr_sync_p0[SYNC_STAGES-1] & ~udr_dly_p1 & warm[SYNC_STAGES];
    end

    always_comb begin
        full        = (count == CW'(DEPTH));
        cmd_valid   = (count != '0);
        pop         = cmd_valid & cmd_ready;
        wr_en       = udr_rise & (~full | pop);
        drop        = udr_rise & full & ~pop;
        cmd_ir      = mem_ir[rd_ptr];
        cmd_data    = mem_data[rd_ptr];
        head_onehot = NUM_CMD'(1) << cmd_ir;
        fill_level  = count;
    end

    // Stage p2: command queue, action pulses and overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_reg         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            overflow       <= 1'b0;
            take_action    <= '0;
            take_no_action <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_ir[i]   <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            // Non-blocking update: a push on this same edge still sees the old ir_reg.
            if (uir_rise) begin
                ir_reg <= ir_in;
            end
            if (wr_en) begin
                mem_ir[wr_ptr]   <= ir_reg;
                mem_data[wr_ptr] <= sr;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow       <= drop | (overflow & ~ovf_clr);
            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                if (cmd_data[ACT_BIT]) begin
                    take_action <= head_onehot;
                end else begin
                    take_no_action <= head_onehot;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_nios_debug_cmd_bridge.sv
// Scoreboard bench for cpu_nios_debug_cmd_bridge: commands queued on push,
// compared at every pop together with the following action pulse.
`timescale 1ns/1ps
module tb_cpu_nios_debug_cmd_bridge;

    localparam int SR_W = 38;
    localparam int IR_W = 2;
    localparam int NC   = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            vs_uir = 1'b0;
    logic            vs_udr = 1'b0;
    logic [IR_W-1:0] ir_in = '0;
    logic [SR_W-1:0] sr = '0;
    logic            cmd_ready = 1'b0;
    logic            ovf_clr = 1'b0;
    logic            cmd_valid;
    logic [IR_W-1:0] cmd_ir;
    logic [SR_W-1:0] cmd_data;
    logic [NC-1:0]   take_action;
    logic [NC-1:0]   take_no_action;
    logic [2:0]      fill_level;
    logic            overflow;

    int checks = 0;
    int errors = 0;
    logic [IR_W+SR_W-1:0] sb[$];
    logic [IR_W-1:0] model_ir = '0;
    logic [NC-1:0]   pend_act = '0;
    logic [NC-1:0]   pend_noact = '0;

    cpu_nios_debug_cmd_bridge dut (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
        .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .take_action(take_action), .take_no_action(take_no_action),
        .fill_level(fill_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [IR_W-1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        tick(2);
        vs_uir = 1'b0;
        tick(4);
        model_ir = ir;
    endtask

    // push_expected=0 models a command the DUT must drop
    task automatic send(input logic [SR_W-1:0] d, input int hold, input bit push_expected);
        sr     = d;
        vs_udr = 1'b1;
        if (push_expected) sb.push_back({model_ir, d});
        tick(hold);
        vs_udr = 1'b0;
        tick(5);
    endtask

    // Pop monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        logic [IR_W+SR_W-1:0] e;
        if (!reset) begin
            check("take_action", 64'(take_action), 64'(pend_act));
            check("take_no_action", 64'(take_no_action), 64'(pend_noact));
        end
        pend_act   = '0;
        pend_noact = '0;
        if (!reset && cmd_valid && cmd_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("pop_ir", 64'(cmd_ir), 64'(e[IR_W+SR_W-1:SR_W]));
                check("pop_data", 64'(cmd_data), 64'(e[SR_W-1:0]));
                if (e[35]) pend_act = NC'(1) << e[IR_W+SR_W-1:SR_W];
                else       pend_noact = NC'(1) << e[IR_W+SR_W-1:SR_W];
            end
        end
    end

    initial begin
        int act_cnt;
        logic [NC-1:0] act_seen;

        #1;
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_fill", 64'(fill_level), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        tick(3);
        reset = 1'b0;
        tick(6);

        // Single command latency and no-action pulse
        cmd_ready = 1'b1;
        set_ir(2'd2);
        sr     = 38'h20_0000_0ABC;
        vs_udr = 1'b1;
        sb.push_back({model_ir, sr});
        tick(1);
        check("lat_e1", 64'(cmd_valid), 64'd0);
        tick(1);
        check("lat_e2", 64'(cmd_valid), 64'd0);
        vs_udr = 1'b0;
        tick(1);
        check("lat_e3", 64'(cmd_valid), 64'd1);
        check("lat_ir", 64'(cmd_ir), 64'd2);
        check("lat_data", 64'(cmd_data), 64'h20_0000_0ABC);
        tick(1);
        check("tna_pulse", 64'(take_no_action), 64'b0100);
        check("ta_quiet", 64'(take_action), 64'd0);
        tick(1);
        check("tna_clear", 64'(take_no_action), 64'd0);
        tick(4);

        // Overflow: five commands into a four-deep queue
        cmd_ready = 1'b0;
        set_ir(2'd1);
        for (int i = 0; i < 5; i++) send(38'h11_0000_0000 + 38'(i), 2, i < 4);
        check("ovf_fill", 64'(fill_level), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_head", 64'(cmd_data), 64'h11_0000_0000);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);
        cmd_ready = 1'b1;
        tick(8);
        check("ovf_drained", 64'(fill_level), 64'd0);
        cmd_ready = 1'b0;

        // Full queue, push and pop on the same edge
        for (int i = 0; i < 4; i++) send(38'h05_0000_0010 + 38'(i), 2, 1'b1);
        check("full_fill", 64'(fill_level), 64'd4);
        sr     = 38'h05_0000_00FF;
        vs_udr = 1'b1;
        sb.push_back({model_ir, sr});
        tick(2);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        check("pp_fill", 64'(fill_level), 64'd4);
        check("pp_ovf", 64'(overflow), 64'd0);
        vs_udr = 1'b0;
        tick(3);
        cmd_ready = 1'b1;
        tick(8);
        check("pp_drained", 64'(fill_level), 64'd0);

        // Simultaneous update-IR and update-DR
        cmd_ready = 1'b0;
        ir_in  = 2'd3;
        sr     = 38'h02_0000_0123;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        sb.push_back({model_ir, sr});
        tick(2);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        tick(5);
        check("simul_ir", 64'(cmd_ir), 64'd1);
        model_ir = 2'd3;
        send(38'h02_0000_0456, 2, 1'b1);
        cmd_ready = 1'b1;
        tick(6);
        check("simul_drained", 64'(fill_level), 64'd0);
        cmd_ready = 1'b0;

        // Reset mid-operation with a strobe in flight
        for (int i = 0; i < 3; i++) send(38'h01_0000_0A00 + 38'(i), 2, 1'b1);
        check("pre_rst_fill", 64'(fill_level), 64'd3);
        vs_udr = 1'b1;
        sr     = 38'h01_0000_0BBB;
        tick(1);
        reset = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_valid", 64'(cmd_valid), 64'd0);
        check("mid_rst_ir", 64'(cmd_ir), 64'd0);
        check("mid_rst_data", 64'(cmd_data), 64'd0);
        check("mid_rst_fill", 64'(fill_level), 64'd0);
        check("mid_rst_act", 64'({take_action, take_no_action}), 64'd0);
        vs_udr = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(10);
        check("post_rst_valid", 64'(cmd_valid), 64'd0);

        // Strobe already high at reset release
        reset  = 1'b1;
        vs_udr = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(10);
        check("rel_high_fill", 64'(fill_level), 64'd0);
        vs_udr = 1'b0;
        tick(5);
        model_ir = 2'd0;

        // Long strobe with action bit set
        set_ir(2'd0);
        cmd_ready = 1'b1;
        sr     = 38'h08_0000_0001;
        vs_udr = 1'b1;
        sb.push_back({model_ir, sr});
        act_cnt  = 0;
        act_seen = '0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            if (i == 19) vs_udr = 1'b0;
            if (take_action != '0) act_cnt++;
            act_seen |= take_action;
        end
        check("long_pulses", 64'(act_cnt), 64'd1);
        check("long_onehot", 64'(act_seen), 64'b0001);
        check("long_fill", 64'(fill_level), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
